// File: rtl/nlms_filter_core_pkg.sv
// -----------------------------------------------------------------------------
// nlms_pkg -- shared types and helpers for the NLMS adaptive filter core.
//
// Contents:
//   state_t          FSM states IDLE, FILT, ERR, DIV, UPD, DONE
//   clog2            ceiling log2 for width derivation
//   acc_width        ACC_W  = COEF_W + DATA_W + clog2(TAPS)
//   ener_width       ENER_W = 2*DATA_W + clog2(TAPS)
//   num_width        NUM_W  = DATA_W + COEF_FRAC - MU_SHIFT
//   sat_signed       clip a wide signed value to the signed range of w bits
// -----------------------------------------------------------------------------
package nlms_pkg;

    typedef enum logic [2:0] {IDLE, FILT, ERR, DIV, UPD, DONE} state_t;

    // Working width for saturation arithmetic; wide enough for any sum/product
    // of the supported parameter ranges.
    localparam int SAT_W = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int coef_w, input int data_w, input int taps);
        return coef_w + data_w + clog2(taps);
    endfunction

    function automatic int ener_width(input int data_w, input int taps);
        return 2 * data_w + clog2(taps);
    endfunction

    function automatic int num_width(input int data_w, input int coef_frac, input int mu_shift);
        return data_w + coef_frac - mu_shift;
    endfunction

    // Symmetric clip to [-2^(w-1), 2^(w-1)-1]; the caller truncates to w bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                           input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/nlms_filter_core_if.sv
// -----------------------------------------------------------------------------
// nlms_filter_core_if -- sample-in / result-out handshake bundle.
//
// Signals:
//   in_valid, in_ready       input handshake (source -> core)
//   x_in, d_in, adapt_en     reference sample, desired sample, adapt request
//   out_valid, out_ready     output handshake (core -> sink)
//   y_out, e_out             filter output and error
// Modports: master = sample source / sink side, slave = filter core side.
// -----------------------------------------------------------------------------
interface nlms_filter_core_if #(
    parameter int DATA_W = 14
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] d_in;
    logic                     adapt_en;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_out;
    logic signed [DATA_W-1:0] e_out;

    modport master (
        output in_valid, x_in, d_in, adapt_en, out_ready,
        input  in_ready, out_valid, y_out, e_out
    );

    modport slave (
        input  in_valid, x_in, d_in, adapt_en, out_ready,
        output in_ready, out_valid, y_out, e_out
    );
endinterface

// File: rtl/nlms_filter_core_div.sv
// -----------------------------------------------------------------------------
// nlms_serial_div -- unsigned restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start       load num/den and begin NUM_W iterations
//   num, den    unsigned numerator and divisor (den must be non-zero)
//   done        high during the cycle whose edge produces the final bit;
//               quot is valid from the following cycle until the next start
//   quot        unsigned quotient
// -----------------------------------------------------------------------------
module nlms_serial_div
    import nlms_pkg::*;
#(
    parameter int NUM_W = 26,
    parameter int DEN_W = 31
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quot
);
    localparam int CW = clog2(NUM_W + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [NUM_W-1:0] sr;     // numerator bits shift out, quotient bits shift in
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_r;
    logic [DEN_W:0]   trial;
    logic             ge;
    logic [DEN_W-1:0] diff;

    always_comb begin
        trial = {rem, sr[NUM_W-1]};
        ge    = trial >= {1'b0, den_r};
        diff  = DEN_W'(trial - {1'b0, den_r});
    end

    assign done = busy && (cnt == CW'(NUM_W - 1));
    assign quot = sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy  <= 1'b0;
            cnt   <= '0;
            sr    <= '0;
            rem   <= '0;
            den_r <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            sr    <= num;
            rem   <= '0;
            den_r <= den;
        end else if (busy) begin
            // Remainder stays below den_r, so the restored value fits DEN_W bits.
            rem <= ge ? diff : trial[DEN_W-1:0];
            sr  <= {sr[NUM_W-2:0], ge};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(NUM_W - 1)) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/nlms_filter_core.sv
// -----------------------------------------------------------------------------
// nlms_filter_core -- TAPS-tap normalised LMS adaptive FIR, one MAC per cycle.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   bus         nlms_filter_core_if.slave: in_valid/in_ready/x_in/d_in/adapt_en,
//               out_valid/out_ready/y_out/e_out
//   coef_clr    zero weights and delay line (honoured in IDLE only)
//   busy        state is not IDLE
//
// Flow: IDLE -> FILT (TAPS) -> ERR -> [DIV (NUM_W) -> UPD (TAPS)] -> DONE.
// Build option: define NLMS_LEAK_EN for the leaky update
//   w[k] = sat(w[k] - (w[k] >>> LEAK_SHIFT) + g*xd[k]).
// -----------------------------------------------------------------------------
module nlms_filter_core
    import nlms_pkg::*;
#(
    parameter int TAPS       = 32,
    parameter int DATA_W     = 14,
    parameter int COEF_W     = 32,
    parameter int COEF_FRAC  = 13,
    parameter int MU_SHIFT   = 1,
    parameter int EPS        = 1,
    parameter int LEAK_SHIFT = 12
) (
    input  logic               clk,
    input  logic               rstn,
    nlms_filter_core_if.slave  bus,
    input  logic               coef_clr,
    output logic               busy
);
    localparam int CNT_W  = clog2(TAPS);
    localparam int ACC_W  = acc_width(COEF_W, DATA_W, TAPS);
    localparam int ENER_W = ener_width(DATA_W, TAPS);
    localparam int NUM_W  = num_width(DATA_W, COEF_FRAC, MU_SHIFT);
    localparam int DEN_W  = ENER_W + 1;
    localparam int PROD_W = COEF_W + DATA_W;
    localparam int SQ_W   = 2 * DATA_W;

    if (TAPS < 2 || MU_SHIFT > COEF_FRAC || EPS < 1 || LEAK_SHIFT < 0) begin : g_bad_param
        $error("nlms_filter_core: illegal parameter combination");
    end

    state_t                   state;
    logic [CNT_W-1:0]         kc;
    logic signed [DATA_W-1:0] xd [TAPS];
    logic signed [COEF_W-1:0] w  [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [ENER_W-1:0]        ener;
    logic signed [DATA_W-1:0] d_lat;
    logic                     adapt_lat;
    logic signed [DATA_W-1:0] y_r, e_r;
    logic signed [DATA_W-1:0] y_out_r, e_out_r;

    logic signed [PROD_W-1:0] prod_filt, prod_upd;
    logic signed [SQ_W-1:0]   sq;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [DATA_W-1:0] y_n, e_n;
    logic signed [DATA_W:0]   e_wide;
    logic [DATA_W-1:0]        e_mag;
    logic [NUM_W-1:0]         div_num;
    logic [DEN_W-1:0]         div_den;
    logic                     div_start, div_done;
    logic [NUM_W-1:0]         div_quot;
    logic signed [COEF_W-1:0] g;
    logic signed [SAT_W-1:0]  upd_sum;
    logic signed [COEF_W-1:0] w_new;

    // NOTE: every always_comb output is assigned on every path, so no latches.
    always_comb begin
        prod_filt = PROD_W'(w[kc]) * PROD_W'(xd[kc]);
        sq        = SQ_W'(xd[kc]) * SQ_W'(xd[kc]);
        acc_sh    = acc >>> COEF_FRAC;
        y_n       = DATA_W'(sat_signed(SAT_W'(acc_sh), DATA_W));
        e_wide    = (DATA_W+1)'(d_lat) - (DATA_W+1)'(y_n);
        e_n       = DATA_W'(sat_signed(SAT_W'(e_wide), DATA_W));
        // |-2^(DATA_W-1)| reads correctly as an unsigned DATA_W-bit value.
        e_mag     = e_n[DATA_W-1] ? (~e_n + DATA_W'(1)) : e_n;
        div_num   = NUM_W'(e_mag) << (COEF_FRAC - MU_SHIFT);
        div_den   = DEN_W'(ener) + DEN_W'(EPS);
        div_start = (state == ERR) && adapt_lat;
        g         = COEF_W'(sat_signed(e_r[DATA_W-1] ? -$signed(SAT_W'(div_quot))
                                                     :  $signed(SAT_W'(div_quot)), COEF_W));
        prod_upd  = PROD_W'(g) * PROD_W'(xd[kc]);
`ifdef NLMS_LEAK_EN
        upd_sum   = SAT_W'(w[kc]) - SAT_W'(w[kc] >>> LEAK_SHIFT) + SAT_W'(prod_upd);
`else
        upd_sum   = SAT_W'(w[kc]) + SAT_W'(prod_upd);
`endif
        w_new     = COEF_W'(sat_signed(upd_sum, COEF_W));
    end

    nlms_serial_div #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .clk   (clk),
        .rstn  (rstn),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quot  (div_quot)
    );

    assign bus.in_ready  = (state == IDLE) && !coef_clr;
    assign bus.out_valid = (state == DONE);
    assign bus.y_out     = y_out_r;
    assign bus.e_out     = e_out_r;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            kc        <= '0;
            // NOTE: weights and delay line must power up at zero, so these
            // arrays are flops with reset rather than an inferred RAM.
            for (int i = 0; i < TAPS; i++) begin
                xd[i] <= '0;
                w[i]  <= '0;
            end
            acc       <= '0;
            ener      <= '0;
            d_lat     <= '0;
            adapt_lat <= 1'b0;
            y_r       <= '0;
            e_r       <= '0;
            y_out_r   <= '0;
            e_out_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_clr) begin
                        for (int i = 0; i < TAPS; i++) begin
                            xd[i] <= '0;
                            w[i]  <= '0;
                        end
                    end else if (bus.in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) xd[i] <= xd[i-1];
                        xd[0]     <= bus.x_in;
                        d_lat     <= bus.d_in;
                        adapt_lat <= bus.adapt_en;
                        acc       <= '0;
                        ener      <= '0;
                        kc        <= '0;
                        state     <= FILT;
                    end
                end
                FILT: begin
                    acc  <= acc + ACC_W'(prod_filt);
                    ener <= ener + ENER_W'($unsigned(sq));
                    kc   <= kc + CNT_W'(1);
                    if (kc == CNT_W'(TAPS - 1)) begin
                        kc    <= '0;
                        state <= ERR;
                    end
                end
                ERR: begin
                    y_r <= y_n;
                    e_r <= e_n;
                    if (adapt_lat) begin
                        state <= DIV;
                    end else begin
                        y_out_r <= y_n;
                        e_out_r <= e_n;
                        state   <= DONE;
                    end
                end
                DIV: begin
                    if (div_done) state <= UPD;
                end
                UPD: begin
                    w[kc] <= w_new;
                    kc    <= kc + CNT_W'(1);
                    if (kc == CNT_W'(TAPS - 1)) begin
                        kc      <= '0;
                        y_out_r <= y_r;
                        e_out_r <= e_r;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nlms_filter_core.sv
// -----------------------------------------------------------------------------
// tb_nlms_filter_core -- directed bench for nlms_filter_core with TAPS=4,
// DATA_W=14, COEF_W=32, COEF_FRAC=13, MU_SHIFT=1, EPS=1 (NUM_W = 26).
// Accept-to-DONE latency: 36 cycles with adaptation, 6 without; DONE is seen
// after the 35th / 5th rising edge following the accepting edge.
// -----------------------------------------------------------------------------
module tb_nlms_filter_core;

    localparam int EDGES_ADAPT = 2 * 4 + 26 + 2 - 1;
    localparam int EDGES_PLAIN = 4 + 2 - 1;

    logic clk = 1'b0;
    logic rstn;
    logic coef_clr;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    nlms_filter_core_if #(.DATA_W(14)) bus ();

    nlms_filter_core #(
        .TAPS(4), .DATA_W(14), .COEF_W(32), .COEF_FRAC(13),
        .MU_SHIFT(1), .EPS(1), .LEAK_SHIFT(12)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .coef_clr (coef_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one sample, then count rising edges until out_valid (bounded).
    task automatic send_sample(input int x, input int d, input logic a, output int edges);
        @(negedge clk);
        bus.x_in     = 14'(x);
        bus.d_in     = 14'(d);
        bus.adapt_en = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges = 0;
        while (!bus.out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic complete_output();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        coef_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.d_in      = '0;
        bus.adapt_en  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (bus.y_out !== 14'(0)) begin n_fail++; $display("FAIL reset_y: got %0d want 0", bus.y_out); end
        n_checks++; if (bus.e_out !== 14'(0)) begin n_fail++; $display("FAIL reset_e: got %0d want 0", bus.e_out); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (dut.w[0] !== 32'(0)) begin n_fail++; $display("FAIL reset_w0: got %0d want 0", dut.w[0]); end
    endtask

    // Fresh weights: y=0, e=50, ener=10000, g=20, w0=2000.
    task automatic test_first_adapt(input string tag);
        int edges;
        send_sample(100, 50, 1'b1, edges);
        n_checks++; if (edges !== EDGES_ADAPT) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", tag, edges, EDGES_ADAPT); end
        n_checks++; if (bus.y_out !== 14'(0)) begin n_fail++; $display("FAIL %s_y: got %0d want 0", tag, bus.y_out); end
        n_checks++; if (bus.e_out !== 14'(50)) begin n_fail++; $display("FAIL %s_e: got %0d want 50", tag, bus.e_out); end
        n_checks++; if (dut.w[0] !== 32'(2000)) begin n_fail++; $display("FAIL %s_w0: got %0d want 2000", tag, dut.w[0]); end
        n_checks++; if (dut.w[1] !== 32'(0)) begin n_fail++; $display("FAIL %s_w1: got %0d want 0", tag, dut.w[1]); end
        complete_output();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_back_to_idle: got %b want 1", tag, bus.in_ready); end
    endtask

    // acc=200000 -> y=24, e=26, ener=20000, g=5 -> w0=2500, w1=500.
    task automatic test_second_adapt();
        int edges;
        send_sample(100, 50, 1'b1, edges);
        n_checks++; if (edges !== EDGES_ADAPT) begin n_fail++; $display("FAIL second_latency: got %0d want %0d", edges, EDGES_ADAPT); end
        n_checks++; if (bus.y_out !== 14'(24)) begin n_fail++; $display("FAIL second_y: got %0d want 24", bus.y_out); end
        n_checks++; if (bus.e_out !== 14'(26)) begin n_fail++; $display("FAIL second_e: got %0d want 26", bus.e_out); end
        n_checks++; if (dut.w[0] !== 32'(2500)) begin n_fail++; $display("FAIL second_w0: got %0d want 2500", dut.w[0]); end
        n_checks++; if (dut.w[1] !== 32'(500)) begin n_fail++; $display("FAIL second_w1: got %0d want 500", dut.w[1]); end
        n_checks++; if (dut.w[2] !== 32'(0)) begin n_fail++; $display("FAIL second_w2: got %0d want 0", dut.w[2]); end
        complete_output();
    endtask

    // acc=50000 -> y=6; e = -8192-6 clips to -8192; no update; then DONE hold.
    task automatic test_no_adapt_sat_hold();
        int edges;
        send_sample(0, -8192, 1'b0, edges);
        n_checks++; if (edges !== EDGES_PLAIN) begin n_fail++; $display("FAIL plain_latency: got %0d want %0d", edges, EDGES_PLAIN); end
        n_checks++; if (bus.y_out !== 14'(6)) begin n_fail++; $display("FAIL plain_y: got %0d want 6", bus.y_out); end
        n_checks++; if (bus.e_out !== 14'(-8192)) begin n_fail++; $display("FAIL plain_e_sat: got %0d want -8192", bus.e_out); end
        n_checks++; if (dut.w[0] !== 32'(2500)) begin n_fail++; $display("FAIL plain_w0: got %0d want 2500", dut.w[0]); end
        n_checks++; if (dut.w[1] !== 32'(500)) begin n_fail++; $display("FAIL plain_w1: got %0d want 500", dut.w[1]); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_checks++; if (bus.y_out !== 14'(6)) begin n_fail++; $display("FAIL hold_y[%0d]: got %0d want 6", i, bus.y_out); end
            n_checks++; if (bus.e_out !== 14'(-8192)) begin n_fail++; $display("FAIL hold_e[%0d]: got %0d want -8192", i, bus.e_out); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        complete_output();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b want 0", busy); end
        n_checks++; if (bus.y_out !== 14'(6)) begin n_fail++; $display("FAIL release_y_kept: got %0d want 6", bus.y_out); end
    endtask

    task automatic test_coef_clr();
        @(negedge clk);
        coef_clr     = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in     = 14'(777);
        bus.adapt_en = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1;
        coef_clr     = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_not_accepted: got busy %b want 0", busy); end
        n_checks++; if (dut.w[0] !== 32'(0)) begin n_fail++; $display("FAIL clr_w0: got %0d want 0", dut.w[0]); end
        n_checks++; if (dut.xd[1] !== 14'(0)) begin n_fail++; $display("FAIL clr_xd1: got %0d want 0", dut.xd[1]); end
        test_first_adapt("after_clr");
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        bus.x_in     = 14'(100);
        bus.d_in     = 14'(50);
        bus.adapt_en = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL middiv_busy: got %b want 1", busy); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL middiv_rst_busy: got %b want 0", busy); end
        n_checks++; if (bus.e_out !== 14'(0)) begin n_fail++; $display("FAIL middiv_rst_e: got %0d want 0", bus.e_out); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL middiv_rst_valid: got %b want 0", bus.out_valid); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL middiv_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (dut.w[0] !== 32'(0)) begin n_fail++; $display("FAIL middiv_w0: got %0d want 0", dut.w[0]); end
        test_first_adapt("after_rst");
    endtask

    initial begin
        test_reset();
        test_first_adapt("first");
        test_second_adapt();
        test_no_adapt_sat_hold();
        test_coef_clr();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
